// File: rtl/modport_dut_if.sv
// Request/response bundle between the driving agent and modport_dut.
// Addresses select a slave by their top bit; read data is registered.
interface modport_dut_if #(
    parameter int AW = 9,
    parameter int DW = 8
);
    logic          transfer;
    logic          read_write;
    logic [AW-1:0] apb_write_paddr;
    logic [DW-1:0] apb_write_data;
    logic [AW-1:0] apb_read_paddr;
    logic [DW-1:0] apb_read_data_out;

    modport master (
        output transfer,
        output read_write,
        output apb_write_paddr,
        output apb_write_data,
        output apb_read_paddr,
        input  apb_read_data_out
    );

    modport slave (
        input  transfer,
        input  read_write,
        input  apb_write_paddr,
        input  apb_write_data,
        input  apb_read_paddr,
        output apb_read_data_out
    );
endinterface

// File: rtl/modport_dut.sv
// APB master plus two memory slaves on one shared bus; top address bit picks the slave.
// Define APB_WAIT_STATE_EN to make each slave insert one wait state per access.
module modport_dut #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic         pclk,
    input  logic         presetn,
    modport_dut_if.slave bus
);
    localparam int DEPTH = 1 << (AW - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          start;

    logic          rw_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;

    logic          psel;
    logic          penable;
    logic          pwrite;
    logic          pready;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;

    logic [1:0]          slv_sel;
    logic [1:0]          slv_ready;
    logic [1:0][DW-1:0]  slv_rdata;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.transfer) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready) state_nxt = bus.transfer ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request is captured only on the edge that enters SETUP, so the
    // inputs are free to change for the rest of the transfer.
    assign start = (state_nxt == SETUP);

    always_ff @(posedge pclk) begin
        if (presetn) begin
            state   <= IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                rw_q    <= bus.read_write;
                addr_q  <= bus.read_write ? bus.apb_read_paddr
                                          : bus.apb_write_paddr;
                wdata_q <= bus.apb_write_data;
            end
            if (state == ACCESS && pready && rw_q)
                rdata_q <= prdata;
        end
    end

    assign psel    = (state == SETUP) || (state == ACCESS);
    assign penable = (state == ACCESS);
    assign pwrite  = ~rw_q;
    assign paddr   = addr_q;
    assign pwdata  = wdata_q;
    assign pready  = |slv_ready;
    assign prdata  = slv_rdata[0] | slv_rdata[1];

    assign bus.apb_read_data_out = rdata_q;

    for (genvar s = 0; s < 2; s++) begin : g_slv
        logic [DW-1:0] mem [DEPTH];
        logic [AW-2:0] idx;
        logic          acc;

        assign idx          = paddr[AW-2:0];
        assign slv_sel[s]   = psel & (paddr[AW-1] == 1'(s));
        assign acc          = slv_sel[s] & penable;
        assign slv_rdata[s] = slv_sel[s] ? mem[idx] : '0;

`ifdef APB_WAIT_STATE_EN
        // Toggles through the two ACCESS cycles: low in the first, high in the second.
        logic wait_q;

        always_ff @(posedge pclk) begin
            if (presetn)
                wait_q <= 1'b0;
            else if (acc)
                wait_q <= ~wait_q;
            else
                wait_q <= 1'b0;
        end

        assign slv_ready[s] = acc & wait_q;
`else
        assign slv_ready[s] = acc;
`endif

        always_ff @(posedge pclk) begin
            if (presetn)
                mem <= '{default: '0};
            else if (slv_ready[s] && pwrite)
                mem[idx] <= pwdata;
        end
    end
endmodule

// File: tb/tb_modport_dut.sv
// Scoreboard bench for modport_dut: reads queue expectations with a due cycle,
// a monitor compares apb_read_data_out on that cycle.
module tb_modport_dut;
    localparam int AW = 9;
    localparam int DW = 8;
`ifdef APB_WAIT_STATE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic pclk;
    logic presetn;
    int   cyc;
    int   compared;
    int   mismatched;

    typedef struct {
        string       nm;
        logic [7:0]  exp;
        int          due;
    } exp_t;

    exp_t sbq[$];

    modport_dut_if #(.AW(AW), .DW(DW)) bif ();

    modport_dut #(.AW(AW), .DW(DW)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bif)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares each queued read exactly on its due cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge pclk);
            #1;
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                if (e.due == cyc) begin
                    chk(e.nm, 32'(bif.apb_read_data_out), 32'(e.exp));
                end else begin
                    compared++;
                    mismatched++;
                    $display("FAIL %s: check missed, due %0d now %0d", e.nm, e.due, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Single transfer from IDLE; inputs are scrambled right after SETUP entry.
    task automatic xfer(input logic rw, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [DW-1:0] exp,
                        input string nm);
        bif.read_write      = rw;
        bif.apb_read_paddr  = rw ? addr : ~addr;
        bif.apb_write_paddr = rw ? ~addr : addr;
        bif.apb_write_data  = data;
        bif.transfer        = 1'b1;
        if (rw) sbq.push_back('{nm, exp, cyc + LAT});
        tick();
        bif.transfer        = 1'b0;
        bif.read_write      = ~rw;
        bif.apb_write_data  = ~data;
        bif.apb_read_paddr  = ~addr;
        bif.apb_write_paddr = ~addr;
        repeat (LAT - 1) tick();
        tick();
    endtask

    initial begin
        logic [AW-1:0] ba [3];
        logic [DW-1:0] bd [3];
        int wait_cnt;

        compared   = 0;
        mismatched = 0;
        ba[0] = 9'h020; ba[1] = 9'h021; ba[2] = 9'h122;
        bd[0] = 8'h11;  bd[1] = 8'h22;  bd[2] = 8'h33;

        bif.transfer        = 1'b0;
        bif.read_write      = 1'b0;
        bif.apb_write_paddr = '0;
        bif.apb_write_data  = '0;
        bif.apb_read_paddr  = '0;
        presetn             = 1'b1;
        repeat (2) tick();
        chk("reset_rdata", 32'(bif.apb_read_data_out), 0);
        chk("reset_state", 32'(dut.state), 0);
        chk("reset_psel_pen", 32'({dut.psel, dut.penable}), 0);
        presetn = 1'b0;
        tick();

        xfer(1'b0, 9'h005, 8'hA5, 8'h00, "wr_005");
        xfer(1'b1, 9'h005, 8'h00, 8'hA5, "raw_005");

        xfer(1'b0, 9'h003, 8'h10, 8'h00, "wr_003");
        xfer(1'b0, 9'h103, 8'h20, 8'h00, "wr_103");
        chk("write_keeps_rdata", 32'(bif.apb_read_data_out), 32'h A5);
        xfer(1'b1, 9'h003, 8'h00, 8'h10, "rd_003");
        xfer(1'b1, 9'h103, 8'h00, 8'h20, "rd_103");
        xfer(1'b1, 9'h004, 8'h00, 8'h00, "rd_004_clear");
        xfer(1'b1, 9'h104, 8'h00, 8'h00, "rd_104_clear");

        // Back-to-back writes: transfer held high, next request set during SETUP.
        bif.read_write      = 1'b0;
        bif.apb_write_paddr = ba[0];
        bif.apb_read_paddr  = ~ba[0];
        bif.apb_write_data  = bd[0];
        bif.transfer        = 1'b1;
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("b2b_setup", 32'({dut.psel, dut.penable}), 32'b10);
            if (w < 2) begin
                bif.apb_write_paddr = ba[w+1];
                bif.apb_write_data  = bd[w+1];
            end else begin
                bif.transfer = 1'b0;
            end
            repeat (LAT - 2) begin
                tick();
                chk("b2b_access", 32'({dut.psel, dut.penable}), 32'b11);
            end
        end
        tick();
        chk("b2b_idle", 32'({dut.psel, dut.penable}), 0);
        xfer(1'b1, ba[0], 8'h00, bd[0], "b2b_rd0");
        xfer(1'b1, ba[1], 8'h00, bd[1], "b2b_rd1");
        xfer(1'b1, ba[2], 8'h00, bd[2], "b2b_rd2");

        xfer(1'b0, 9'h010, 8'h3C, 8'h00, "wr_stable");
        xfer(1'b1, 9'h010, 8'h00, 8'h3C, "rd_stable");

        // Write 0xFF to 0x007, reset lands on the edge that would end ACCESS.
        bif.read_write      = 1'b0;
        bif.apb_write_paddr = 9'h007;
        bif.apb_write_data  = 8'hFF;
        bif.transfer        = 1'b1;
        tick();
        bif.transfer = 1'b0;
        tick();
        chk("pre_abort_access", 32'({dut.psel, dut.penable}), 32'b11);
        presetn = 1'b1;
        tick();
        presetn = 1'b0;
        chk("abort_psel_pen", 32'({dut.psel, dut.penable}), 0);
        chk("abort_rdata", 32'(bif.apb_read_data_out), 0);
        tick();
        xfer(1'b1, 9'h007, 8'h00, 8'h00, "rd_007_aborted");
        xfer(1'b1, 9'h010, 8'h00, 8'h00, "rd_010_cleared");

        wait_cnt = 0;
        while (sbq.size() > 0 && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        if (sbq.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d pending, expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/modport_dut.md
MODPORT_DUT -- requirements
Module: modport_dut

Interface
REQ-001 SHALL have parameter AW, default 9, address width; bit AW-1 is the slave-select bit.
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have port pclk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port presetn  input  1  reset; synchronous, active-high (asserted when 1).
REQ-005 SHALL have port transfer  input  1  transfer request; sampled each rising edge.
REQ-006 SHALL have port read_write  input  1  direction: 1 = read, 0 = write.
REQ-007 SHALL have port apb_write_paddr  input  AW  write address.
REQ-008 SHALL have port apb_write_data  input  DW  write data.
REQ-009 SHALL have port apb_read_paddr  input  AW  read address.
REQ-010 SHALL have port apb_read_data_out  output  DW  registered read data; holds the last completed read.

Function
REQ-011 SHALL contain one internal APB master and two internal APB slaves on a shared psel/penable/pwrite/paddr/pwdata/prdata/pready bus.
REQ-012 Each slave SHALL hold a 2^(AW-1) x DW memory.
REQ-013 Address bit AW-1 SHALL select the slave: 0 = slave 1, 1 = slave 2; bits AW-2:0 index that slave's memory.
REQ-014 The master FSM SHALL have the states IDLE, SETUP and ACCESS.
REQ-015 IDLE: transfer=1 SHALL go to SETUP; otherwise the FSM SHALL stay in IDLE.
REQ-016 SETUP SHALL always go to ACCESS.
REQ-017 ACCESS with pready=0 SHALL stay in ACCESS.
REQ-018 ACCESS with pready=1 and transfer=1 SHALL go to SETUP (back-to-back transfer).
REQ-019 ACCESS with pready=1 and transfer=0 SHALL go to IDLE.
REQ-020 On every edge entering SETUP, the master SHALL latch read_write, the address and apb_write_data.
REQ-021 The latched address SHALL be apb_read_paddr when read_write=1 and apb_write_paddr when read_write=0.
REQ-022 Input changes during SETUP and ACCESS SHALL be ignored.
REQ-023 SETUP SHALL drive psel=1 and penable=0; ACCESS SHALL drive psel=1 and penable=1; IDLE SHALL drive psel=0 and penable=0.
REQ-024 pwrite SHALL equal the inverse of the latched read_write.
REQ-025 A write SHALL update the selected memory word on the edge that ends ACCESS with pready=1.
REQ-026 A read SHALL load apb_read_data_out from the selected word on the edge that ends ACCESS with pready=1.
REQ-027 Base latency SHALL be 3 edges from the edge sampling transfer=1 in IDLE to completion.
REQ-028 A read-after-write to the same address SHALL return the newly written data.
REQ-029 Each slave SHALL respond only while its select is active; the unselected slave's memory SHALL be unchanged.

Reset
REQ-030 presetn=1 at a rising edge SHALL force IDLE, drive psel=0 and penable=0, and set apb_read_data_out=0.
REQ-031 presetn=1 at a rising edge SHALL clear both memories to 0.
REQ-032 Reset asserted during SETUP or ACCESS SHALL abort the transfer with no memory write and no read-data update.
REQ-033 Reset SHALL take priority over transfer on the same edge.

Configuration
REQ-034 With macro APB_WAIT_STATE_EN defined, each slave SHALL drive pready=0 in the first ACCESS cycle and pready=1 in the second, giving 4-edge latency.
REQ-035 With APB_WAIT_STATE_EN undefined, pready SHALL be 1 in every ACCESS cycle, giving 3-edge latency.

Verification
REQ-036 Reset: presetn=1 for 2 cycles -> apb_read_data_out=0 and FSM in IDLE.
REQ-037 Single write then read: write addr 0x005 data 0xA5, then read addr 0x005 -> apb_read_data_out=0xA5 on the 3rd edge after the read request (4th with APB_WAIT_STATE_EN).
REQ-038 Slave split: write 0x10 to addr 0x003 and 0x20 to addr 0x103; read addr 0x003 -> 0x10; read addr 0x103 -> 0x20.
REQ-039 Back-to-back: hold transfer=1 across 3 writes -> FSM goes ACCESS->SETUP with no IDLE, one write per 2 cycles, and all 3 writes read back correctly.
REQ-040 Reset mid-ACCESS: write 0xFF to addr 0x007 with reset asserted in ACCESS -> a subsequent read of 0x007 returns 0x00.
REQ-041 Input stability: change apb_write_data during ACCESS -> the value latched at SETUP entry is the one stored.
